// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder for the memory stage.
// Serves RV32I loads/stores from an internal word array with fixed latency.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            accept;
    logic            commit;

    logic [31:0]     lat_addr;
    logic            lat_write;
    logic [2:0]      lat_f3;
    logic [31:0]     lat_wdata;

    logic [31:0]     c_addr;
    logic            c_write;
    logic [2:0]      c_f3;
    logic [31:0]     c_wdata;

    logic [AW-1:0]   idx;
    logic [1:0]      lane;
    logic            illegal;
    logic            misal;
    logic            out_rng;
    logic            err;
    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     ld_val;
    logic [31:0]     wr_mask;
    logic [31:0]     wr_data;

    logic [31:0]     mem [DEPTH_WORDS];

    // State and latency counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, handshake outputs and commit-edge detection.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        commit     = 1'b0;
        accept     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = rst;
                if (req_valid && rst) begin
                    accept = 1'b1;
                    cnt_d  = CW'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture at acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_f3    <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_addr  <= req_addr;
            lat_write <= req_write;
            lat_f3    <= req_funct3;
            lat_wdata <= req_wdata;
        end
    end

    // Single-cycle latency commits on the accept edge, so bypass the latch.
    always_comb begin
        if (state_q == IDLE) begin
            c_addr  = req_addr;
            c_write = req_write;
            c_f3    = req_funct3;
            c_wdata = req_wdata;
        end else begin
            c_addr  = lat_addr;
            c_write = lat_write;
            c_f3    = lat_f3;
            c_wdata = lat_wdata;
        end
    end

    // Address decode and error classification.
    always_comb begin
        idx     = c_addr[AW+1:2];
        lane    = c_addr[1:0];
        illegal = c_write ? (c_f3 > 3'd2)
                          : (c_f3 == 3'd3 || c_f3 > 3'd5);
        misal   = (c_f3[1:0] == 2'd1 && c_addr[0])
               || (c_f3[1:0] == 2'd2 && lane != 2'd0);
        out_rng = (c_addr >> (AW + 2)) != 32'd0;
        err     = illegal || misal || out_rng;
    end

    // Load extraction and extension.
    always_comb begin
        rd_word = mem[idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = c_addr[1] ? rd_word[31:16] : rd_word[15:0];
        ld_val  = '0;
        unique case (1'b1)
            (c_f3 == 3'd0): ld_val = {{24{rd_byte[7]}}, rd_byte};
            (c_f3 == 3'd4): ld_val = {24'd0, rd_byte};
            (c_f3 == 3'd1): ld_val = {{16{rd_half[15]}}, rd_half};
            (c_f3 == 3'd5): ld_val = {16'd0, rd_half};
            (c_f3 == 3'd2): ld_val = rd_word;
            default:        ld_val = '0;
        endcase
    end

    // Store lane mask and replicated data.
    always_comb begin
        wr_mask = 32'hFFFF_FFFF;
        wr_data = c_wdata;
        unique case (c_f3[1:0])
            2'd0: begin
                wr_mask = 32'h0000_00FF << {lane, 3'b000};
                wr_data = {4{c_wdata[7:0]}};
            end
            2'd1: begin
                wr_mask = c_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                wr_data = {2{c_wdata[15:0]}};
            end
            default: begin
                wr_mask = 32'hFFFF_FFFF;
                wr_data = c_wdata;
            end
        endcase
    end

    // Backing store write on the commit edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && c_write && !err) begin
            mem[idx] <= (rd_word & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    // Response registers, held until the response is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else if (commit) begin
            resp_error <= err;
            resp_rdata <= (err || c_write) ? 32'd0 : ld_val;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: vector table, corner sequences and random model check.
// Two instances: LATENCY=2 (main) and LATENCY=1 (selected with sel).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        rr0, rv0, re0, rr1, rv1, re1;
    logic [31:0] rd0, rd1;
    logic        req_ready_m, resp_valid_m, resp_error_m;
    logic [31:0] resp_rdata_m;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] mm [4096];

    typedef struct {
        string       nm;
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel), .req_ready(rr0),
        .req_addr(req_addr), .req_write(req_write),
        .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(rv0), .resp_ready(resp_ready & ~sel),
        .resp_rdata(rd0), .resp_error(re0)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel), .req_ready(rr1),
        .req_addr(req_addr), .req_write(req_write),
        .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(rv1), .resp_ready(resp_ready & sel),
        .resp_rdata(rd1), .resp_error(re1)
    );

    assign req_ready_m  = sel ? rr1 : rr0;
    assign resp_valid_m = sel ? rv1 : rv0;
    assign resp_rdata_m = sel ? rd1 : rd0;
    assign resp_error_m = sel ? re1 : re0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    endtask

    task automatic add(input string nm, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input logic er);
        vec_t v;
        v.nm = nm; v.w = w; v.f3 = f3; v.a = a; v.d = d;
        v.rd = rd; v.er = er;
        tbl.push_back(v);
    endtask

    // One full transaction; lat counts edges from acceptance to resp_valid.
    task automatic xact(input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er,
                        output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready_m && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
        req_write  = 1'($urandom);
        lat = 1;
        while (!resp_valid_m && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = resp_rdata_m;
        er = resp_error_m;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    // Reference: byte-addressed memory, access size from funct3.
    task automatic model(input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic er);
        int sz;
        logic legal;
        logic [31:0] v;
        sz = 1 << f3[1:0];
        legal = w ? (f3 <= 3'd2)
                  : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                     f3 == 3'd4 || f3 == 3'd5);
        rd = 32'd0;
        er = 1'b0;
        if (!legal || (a % sz) != 0 || a >= 32'h1000) begin
            er = 1'b1;
        end else if (w) begin
            for (int i = 0; i < sz; i++) mm[a + i] = d[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < sz; i++) v |= 32'(mm[a + i]) << (8 * i);
            if (!f3[2] && sz < 4 && v[8*sz-1]) v |= 32'hFFFF_FFFF << (8 * sz);
            rd = v;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, erd, a, d;
        logic er, eer, w;
        logic [2:0] f3;
        int lat, n;

        sel = 1'b0;
        rst = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready_m), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid_m), 32'd0);
        chk("rst_rdata", resp_rdata_m, 32'd0);
        chk("rst_error", 32'(resp_error_m), 32'd0);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready_m), 32'd1);

        add("sw_10", 1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        add("lw_10", 0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        add("sw_20", 1, 3'd2, 32'h20, 32'h11223344, 32'h0, 0);
        add("sb_21", 1, 3'd0, 32'h21, 32'h000000F0, 32'h0, 0);
        add("lw_20", 0, 3'd2, 32'h20, 32'h0, 32'h1122F044, 0);
        add("lb_21", 0, 3'd0, 32'h21, 32'h0, 32'hFFFFFFF0, 0);
        add("lbu_21", 0, 3'd4, 32'h21, 32'h0, 32'h000000F0, 0);
        add("lhu_22", 0, 3'd5, 32'h22, 32'h0, 32'h00001122, 0);
        add("lh_20", 0, 3'd1, 32'h20, 32'h0, 32'hFFFFF044, 0);
        add("lw_22_mis", 0, 3'd2, 32'h22, 32'h0, 32'h0, 1);
        add("sh_13_mis", 1, 3'd1, 32'h13, 32'hAAAAAAAA, 32'h0, 1);
        add("lw_10_kept", 0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        add("lw_1000_rng", 0, 3'd2, 32'h1000, 32'h0, 32'h0, 1);
        add("lw_hi_rng", 0, 3'd2, 32'h80000010, 32'h0, 32'h0, 1);
        add("ld_f3_3", 0, 3'd3, 32'h10, 32'h0, 32'h0, 1);
        add("ld_f3_7", 0, 3'd7, 32'h10, 32'h0, 32'h0, 1);
        add("st_f3_4", 1, 3'd4, 32'h20, 32'hFFFFFFFF, 32'h0, 1);
        add("lw_20_kept", 0, 3'd2, 32'h20, 32'h0, 32'h1122F044, 0);
        add("sh_22", 1, 3'd1, 32'h22, 32'h12345678, 32'h0, 0);
        add("lw_20_sh", 0, 3'd2, 32'h20, 32'h0, 32'h5678F044, 0);
        add("lb_22", 0, 3'd0, 32'h22, 32'h0, 32'h00000078, 0);
        add("lbu_23", 0, 3'd4, 32'h23, 32'h0, 32'h00000056, 0);

        foreach (tbl[i]) begin
            xact(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].d, rd, er, lat);
            chk({tbl[i].nm, "_rdata"}, rd, tbl[i].rd);
            chk({tbl[i].nm, "_err"}, 32'(er), 32'(tbl[i].er));
            chk({tbl[i].nm, "_lat"}, 32'(lat), 32'd2);
        end

        // Response backpressure with a competing request held high.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_funct3 = 3'd2;
        req_addr = 32'h10;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_addr = 32'h20;
        n = 0;
        while (!resp_valid_m && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_lat", 32'(n + 1), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid_m), 32'd1);
            chk("bp_rdata", resp_rdata_m, 32'hDEADBEEF);
            chk("bp_err", 32'(resp_error_m), 32'd0);
            chk("bp_req_ready", 32'(req_ready_m), 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        chk("bp_valid_drop", 32'(resp_valid_m), 32'd0);
        chk("bp_ready_back", 32'(req_ready_m), 32'd1);

        // Reset during WAIT discards a pending store.
        xact(1, 3'd2, 32'h30, 32'h0, rd, er, lat);
        chk("pre30_err", 32'(er), 32'd0);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_funct3 = 3'd2;
        req_addr = 32'h30;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rstw_ready", 32'(req_ready_m), 32'd0);
        rst = 1'b0;
        #1;
        chk("rstw_valid", 32'(resp_valid_m), 32'd0);
        chk("rstw_req_ready", 32'(req_ready_m), 32'd0);
        repeat (2) @(negedge clk);
        chk("rstw_valid_hold", 32'(resp_valid_m), 32'd0);
        rst = 1'b1;
        xact(0, 3'd2, 32'h30, 32'h0, rd, er, lat);
        chk("rstw_lw30", rd, 32'h0);
        chk("rstw_lw30_err", 32'(er), 32'd0);

        // Reset during RESP drops the response at once.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_funct3 = 3'd2;
        req_addr = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rstr_pre_valid", 32'(resp_valid_m), 32'd1);
        rst = 1'b0;
        #1;
        chk("rstr_valid", 32'(resp_valid_m), 32'd0);
        chk("rstr_rdata", resp_rdata_m, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstr_ready", 32'(req_ready_m), 32'd1);

        // Single-cycle latency instance.
        sel = 1'b1;
        xact(1, 3'd2, 32'h40, 32'h000055AA, rd, er, lat);
        chk("l1_sw_lat", 32'(lat), 32'd1);
        chk("l1_sw_err", 32'(er), 32'd0);
        xact(0, 3'd2, 32'h40, 32'h0, rd, er, lat);
        chk("l1_lw_lat", 32'(lat), 32'd1);
        chk("l1_lw_rdata", rd, 32'h000055AA);
        xact(0, 3'd0, 32'h41, 32'h0, rd, er, lat);
        chk("l1_lb_rdata", rd, 32'h00000055);
        xact(0, 3'd1, 32'h41, 32'h0, rd, er, lat);
        chk("l1_lh_mis", 32'(er), 32'd1);
        sel = 1'b0;

        // Preload the random window, then random traffic against the model.
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            model(1, 3'd2, 32'(i * 4), d, erd, eer);
            xact(1, 3'd2, 32'(i * 4), d, rd, er, lat);
        end
        for (int i = 0; i < 300; i++) begin
            w = 1'($urandom);
            f3 = 3'($urandom);
            a = $urandom_range(0, 255);
            if ($urandom_range(0, 15) == 0) a |= 32'h1 << $urandom_range(12, 31);
            d = $urandom;
            model(w, f3, a, d, erd, eer);
            xact(w, f3, a, d, rd, er, lat);
            chk("rnd_rdata", rd, erd);
            chk("rnd_err", 32'(er), 32'(eer));
            chk("rnd_lat", 32'(lat), 32'd2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
